// File: rtl/inst_encoder_if.sv
// Request / instruction-memory bus for inst_encoder.
//   req_*        : decoded instruction request (valid/ready handshake)
//   imem_*       : encoded-word write port toward instruction memory
//   inst_count   : words written since reset/clear
//   done, err    : halt written / illegal op seen (sticky)
// master = environment side (request source + memory), slave = encoder.
interface inst_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [4:0]  req_shamt;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        imem_we;
    logic        imem_wr_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] inst_count;
    logic        done;
    logic        err;

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target,
        output imem_wr_ready,
        input  req_ready, imem_we, imem_addr, imem_wdata, inst_count, done, err
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target,
        input  imem_wr_ready,
        output req_ready, imem_we, imem_addr, imem_wdata, inst_count, done, err
    );
endinterface

// File: rtl/inst_encoder.sv
// Encodes instruction requests into 32-bit MIPS-style words, buffers them in
// a small FIFO and streams them to instruction memory at consecutive word
// addresses starting at BASE_ADDR.
// Ports: clk, rst (async, active high), clear (sync restart), bus (slave view
// of inst_encoder_if: request handshake, imem write port, count/done/err).
//
// state | meaning
// RUN   | accepting requests and draining encoded words to memory
// DONE  | halt word written; idle until rst or clear
module inst_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    inst_encoder_if.slave  bus
);
    localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
    localparam logic [3:0]  OP_HALT   = 4'd14;
    localparam logic [3:0]  OP_ILL    = 4'd15;

    typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   occ_q, occ_d;
    state_t        state_q, state_d;
    logic          halt_acc_q, halt_acc_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;

    logic [31:0]   enc_word;
    logic          fifo_full, fifo_empty, accept, push, pop;

    assign fifo_full  = (occ_q == (PW+1)'(DEPTH));
    assign fifo_empty = (occ_q == '0);

    assign bus.req_ready  = (state_q == RUN) && !fifo_full && !halt_acc_q;
    assign bus.imem_we    = !fifo_empty;
    assign bus.imem_wdata = mem_q[rd_ptr_q];
    assign bus.imem_addr  = BASE_ADDR + {14'd0, cnt_q, 2'b00};
    assign bus.inst_count = cnt_q;
    assign bus.done       = (state_q == DONE);
    assign bus.err        = err_q;

    // clear wins over any same-cycle push or pop
    assign accept = bus.req_valid && bus.req_ready;
    assign push   = accept && (bus.req_op != OP_ILL) && !clear;
    assign pop    = bus.imem_we && bus.imem_wr_ready && !clear;

    always_comb begin
        logic [5:0] funct;
        logic [5:0] opcode;
        logic [4:0] rs_f;
        logic [4:0] sh_f;
        funct    = 6'b000000;
        opcode   = 6'b000000;
        rs_f     = bus.req_rs;
        sh_f     = 5'd0;
        enc_word = 32'h0;
        case (bus.req_op)
            4'd0: funct = 6'b100000;
            4'd1: funct = 6'b100010;
            4'd2: funct = 6'b100100;
            4'd3: funct = 6'b100101;
            4'd4: funct = 6'b101010;
            4'd5: begin
                funct = 6'b000000;
                rs_f  = 5'd0;
                sh_f  = bus.req_shamt;
            end
            4'd6:  opcode = 6'b001000;
            4'd7:  opcode = 6'b001100;
            4'd8:  opcode = 6'b001101;
            4'd9:  opcode = 6'b100011;
            4'd10: opcode = 6'b101011;
            4'd11: opcode = 6'b000100;
            4'd12: opcode = 6'b000101;
            default: ;
        endcase
        if (bus.req_op <= 4'd5)
            enc_word = {6'b000000, rs_f, bus.req_rt, bus.req_rd, sh_f, funct};
        else if (bus.req_op <= 4'd12)
            enc_word = {opcode, bus.req_rs, bus.req_rt, bus.req_imm};
        else if (bus.req_op == 4'd13)
            enc_word = {6'b000010, bus.req_target};
        else if (bus.req_op == OP_HALT)
            enc_word = HALT_WORD;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        state_d    = state_q;
        halt_acc_d = halt_acc_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            state_d    = RUN;
            halt_acc_d = 1'b0;
            err_d      = 1'b0;
            cnt_d      = 16'd0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                cnt_d    = cnt_q + 16'd1;
                // halt is the only op that can produce this word
                if (bus.imem_wdata == HALT_WORD)
                    state_d = DONE;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
            if (accept && bus.req_op == OP_HALT)
                halt_acc_d = 1'b1;
            if (accept && bus.req_op == OP_ILL)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            state_q    <= RUN;
            halt_acc_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            state_q    <= state_d;
            halt_acc_q <= halt_acc_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem_q[wr_ptr_q] <= enc_word;
    end
endmodule
